// File: rtl/bkm_pkg.sv
// Shared digit encodings, FSM states and digit decode for the BKM iteration core.
// Saturating build is selected by defining BKM_ITER_SAT_EN.
package bkm_pkg;

  localparam logic [1:0] BKM_D_ZERO = 2'b00;
  localparam logic [1:0] BKM_D_POS  = 2'b01;
  localparam logic [1:0] BKM_D_NEG  = 2'b11;
  localparam logic [1:0] BKM_D_RSVD = 2'b10;

  typedef enum logic [1:0] {
    BKM_ST_IDLE = 2'd0,
    BKM_ST_RUN  = 2'd1,
    BKM_ST_DONE = 2'd2
  } bkm_state_e;

  // Reserved code decodes to zero, same as BKM_D_ZERO.
  function automatic logic signed [1:0] bkm_digit(
    input logic [1:0] d
  );
    unique case (1'b1)
      d == BKM_D_POS: return 2'sb01;
      d == BKM_D_NEG: return 2'sb11;
      default:        return 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/multiply_by_d.sv
// Combinational complex product d*E for a digit pair in {-1,0,+1}.
// Width is the caller's choice; operands arrive already sign-extended.
module multiply_by_d
  import bkm_pkg::*;
#(
  parameter int W = 17
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic [1:0]          dx,
  input  logic [1:0]          dy,
  output logic signed [W-1:0] px,
  output logic signed [W-1:0] py
);

  function automatic logic signed [W-1:0] term(
    input logic [1:0]          d,
    input logic signed [W-1:0] v
  );
    logic signed [1:0] s;
    s = bkm_digit(d);
    unique case (1'b1)
      s == 2'sb01: return v;
      s == 2'sb11: return -v;
      default:     return '0;
    endcase
  endfunction

  always_comb begin
    px = term(dx, x) - term(dy, y);
    py = term(dx, y) + term(dy, x);
  end

endmodule

// File: rtl/bkm_iter_mult.sv
// Sequential BKM iteration core: E <- E + d_n*E*2^-n for n = 1..N.
// Define BKM_ITER_SAT_EN to saturate each update instead of wrapping.
module bkm_iter_mult
  import bkm_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  input  logic         d_valid,
  output logic         d_ready,
  input  logic [1:0]   d_x,
  input  logic [1:0]   d_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic         d_err
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] NLAST = CW'(N);

  bkm_state_e state, state_nx;

  logic signed [W-1:0] x_r, y_r;
  logic [CW-1:0]       n_r;
  logic                err_r;

  logic signed [W:0] xe, ye, px, py, sx, sy;

  logic ld, step, rsvd;

  function automatic logic signed [W-1:0] fit(
    input logic signed [W:0] s
  );
`ifdef BKM_ITER_SAT_EN
    if (s[W] != s[W-1])
      return s[W] ? {1'b1, {(W-1){1'b0}}}
                  : {1'b0, {(W-1){1'b1}}};
`endif
    return s[W-1:0];
  endfunction

  assign xe = {x_r[W-1], x_r};
  assign ye = {y_r[W-1], y_r};

  multiply_by_d #(.W(W + 1)) u_mul (
    .x  (xe),
    .y  (ye),
    .dx (d_x),
    .dy (d_y),
    .px (px),
    .py (py)
  );

  assign sx = xe + (px >>> n_r);
  assign sy = ye + (py >>> n_r);

  assign ld   = (state == BKM_ST_IDLE) && in_valid;
  assign step = (state == BKM_ST_RUN) && d_valid;
  assign rsvd = (d_x == BKM_D_RSVD) || (d_y == BKM_D_RSVD);

  always_ff @(posedge clk) begin
    if (rst) state <= BKM_ST_IDLE;
    else if (ena) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      BKM_ST_IDLE:
        if (in_valid) state_nx = BKM_ST_RUN;
      BKM_ST_RUN:
        if (d_valid && n_r == NLAST)
          state_nx = BKM_ST_DONE;
      BKM_ST_DONE:
        if (out_ready) state_nx = BKM_ST_IDLE;
      default: state_nx = BKM_ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == BKM_ST_IDLE);
    d_ready   = (state == BKM_ST_RUN);
    out_valid = (state == BKM_ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_r   <= '0;
      y_r   <= '0;
      n_r   <= '0;
      err_r <= 1'b0;
    end else if (ena) begin
      if (ld) begin
        x_r   <= x_in;
        y_r   <= y_in;
        n_r   <= CW'(1);
        err_r <= 1'b0;
      end else if (step) begin
        x_r   <= fit(sx);
        y_r   <= fit(sy);
        n_r   <= n_r + CW'(1);
        err_r <= err_r | rsvd;
      end
    end
  end

  assign x_out = x_r;
  assign y_out = y_r;
  assign d_err = err_r;

endmodule

// File: tb/tb_bkm_iter_mult.sv
// Randomised self-checking bench for bkm_iter_mult (W=16, N=4).
// Reference model iterates the complex recurrence with integer arithmetic.
module tb_bkm_iter_mult;

  localparam int W = 16;
  localparam int N = 4;

  logic clk = 0;
  logic rst, ena, in_valid, in_ready;
  logic [W-1:0] x_in, y_in, x_out, y_out;
  logic d_valid, d_ready, out_valid, out_ready, d_err;
  logic [1:0] d_x, d_y;

  int checks = 0;
  int passed = 0;

  logic [1:0] dq_x [N];
  logic [1:0] dq_y [N];
  int gap [N];
  int pause_at, pause_len, junk_at;
  logic junk_rdy;

  always #5 clk = ~clk;

  bkm_iter_mult #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_x(d_x), .d_y(d_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .d_err(d_err)
  );

  function automatic int dval(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b11) return -1;
    return 0;
  endfunction

  function automatic int fit16(input int s);
    logic [15:0] t;
`ifdef BKM_ITER_SAT_EN
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
`endif
    t = s[15:0];
    return int'($signed(t));
  endfunction

  task automatic model(input int xi, input int yi,
                       output logic [15:0] ex, output logic [15:0] ey,
                       output logic ee);
    int x, y, px, py, a, b;
    x = xi; y = yi; ee = 0;
    for (int n = 1; n <= N; n++) begin
      a = dval(dq_x[n-1]);
      b = dval(dq_y[n-1]);
      if (dq_x[n-1] == 2'b10 || dq_y[n-1] == 2'b10) ee = 1;
      px = a * x - b * y;
      py = a * y + b * x;
      x = fit16(x + (px >>> n));
      y = fit16(y + (py >>> n));
    end
    ex = x[15:0];
    ey = y[15:0];
  endtask

  task automatic set_digits(input logic [1:0] a0, b0, a1, b1,
                            input logic [1:0] a2, b2, a3, b3);
    dq_x[0] = a0; dq_y[0] = b0; dq_x[1] = a1; dq_y[1] = b1;
    dq_x[2] = a2; dq_y[2] = b2; dq_x[3] = a3; dq_y[3] = b3;
    for (int i = 0; i < N; i++) gap[i] = 0;
    pause_at = -1; pause_len = 0; junk_at = -1;
  endtask

  task automatic run_op(input logic [15:0] xi, input logic [15:0] yi,
                        output logic [15:0] ox, output logic [15:0] oy,
                        output logic oe, output int cyc);
    int k, g;
    in_valid = 1; x_in = xi; y_in = yi;
    @(negedge clk);
    cyc = 1; in_valid = 0; k = 0; g = 0;
    while (!out_valid && cyc < 100) begin
      ena = 1; d_valid = 0;
      if (cyc >= pause_at && cyc < pause_at + pause_len) begin
        ena = 0; d_valid = 1; d_x = 2'b01; d_y = 2'b01;
      end else if (k < N) begin
        if (g < gap[k]) g++;
        else begin
          d_valid = 1; d_x = dq_x[k]; d_y = dq_y[k];
          k++; g = 0;
        end
      end
      if (cyc == junk_at) begin
        in_valid = 1; x_in = 16'($urandom); junk_rdy = in_ready;
      end
      @(negedge clk);
      cyc++; in_valid = 0;
    end
    d_valid = 0; ena = 1;
    ox = x_out; oy = y_out; oe = d_err;
  endtask

  task automatic consume();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, d_ready, out_valid, d_err} !== 4'b1000)
      $display("FAIL reset_flags got %b want 1000",
               {in_ready, d_ready, out_valid, d_err});
    else passed++;
    checks++;
    if (x_out !== 16'd0 || y_out !== 16'd0)
      $display("FAIL reset_data got %0d,%0d want 0,0", x_out, y_out);
    else passed++;
    rst = 0;
    @(negedge clk);
  endtask

  task automatic directed(input string nm, input logic [15:0] xi,
                          input logic [15:0] yi, input logic [15:0] wx,
                          input logic [15:0] wy, input logic we);
    logic [15:0] ox, oy; logic oe; int cyc;
    run_op(xi, yi, ox, oy, oe, cyc);
    checks++;
    if (ox !== wx || oy !== wy || oe !== we || cyc != N + 1)
      $display("FAIL %s got %0d,%0d err=%b lat=%0d want %0d,%0d err=%b lat=%0d",
               nm, $signed(ox), $signed(oy), oe, cyc,
               $signed(wx), $signed(wy), we, N + 1);
    else passed++;
    consume();
  endtask

  task automatic test_directed();
    set_digits(2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00);
    directed("real_digits", 16'd1024, 16'd0, 16'd2295, 16'd0, 1'b0);
    set_digits(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    directed("imag_digit", 16'd1024, 16'd0, 16'd1024, 16'd512, 1'b0);
    set_digits(2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    directed("floor_rsvd", -16'sd3, 16'd0, -16'sd5, 16'd0, 1'b1);
    set_digits(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
`ifdef BKM_ITER_SAT_EN
    directed("overflow", 16'd32000, 16'd0, 16'd32767, 16'd0, 1'b0);
`else
    directed("overflow", 16'd32000, 16'd0, -16'sd17536, 16'd0, 1'b0);
`endif
  endtask

  task automatic test_random();
    logic [15:0] ox, oy, ex, ey; logic oe, ee; int cyc, xi, yi;
    for (int t = 0; t < 24; t++) begin
      set_digits(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      xi = $urandom_range(32000) - 16000;
      yi = $urandom_range(32000) - 16000;
      model(xi, yi, ex, ey, ee);
      run_op(16'(xi), 16'(yi), ox, oy, oe, cyc);
      checks++;
      if (ox !== ex || oy !== ey || oe !== ee || cyc != N + 1)
        $display("FAIL random_%0d got %0d,%0d err=%b lat=%0d want %0d,%0d err=%b lat=%0d",
                 t, $signed(ox), $signed(oy), oe, cyc,
                 $signed(ex), $signed(ey), ee, N + 1);
      else passed++;
      consume();
    end
  endtask

  task automatic test_hold_output();
    logic [15:0] ox, oy, ex, ey; logic oe, ee; int cyc;
    set_digits(2'b11, 2'b01, 2'b01, 2'b11, 2'b00, 2'b01, 2'b01, 2'b01);
    model(5000, -7000, ex, ey, ee);
    run_op(16'd5000, -16'sd7000, ox, oy, oe, cyc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || x_out !== ex || y_out !== ey)
        $display("FAIL hold_%0d got v=%b %0d,%0d want v=1 %0d,%0d", i,
                 out_valid, $signed(x_out), $signed(y_out),
                 $signed(ex), $signed(ey));
      else passed++;
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL after_consume got v=%b rdy=%b want v=0 rdy=1",
               out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_in_pulse_run();
    logic [15:0] ox, oy, ex, ey; logic oe, ee; int cyc;
    set_digits(2'b01, 2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01);
    junk_at = 2;
    model(3000, 4000, ex, ey, ee);
    run_op(16'd3000, 16'd4000, ox, oy, oe, cyc);
    checks++;
    if (ox !== ex || oy !== ey || cyc != N + 1 || junk_rdy !== 1'b0)
      $display("FAIL in_pulse got %0d,%0d lat=%0d rdy=%b want %0d,%0d lat=%0d rdy=0",
               $signed(ox), $signed(oy), cyc, junk_rdy,
               $signed(ex), $signed(ey), N + 1);
    else passed++;
    consume();
  endtask

  task automatic test_d_gaps();
    logic [15:0] ox, oy, ex, ey; logic oe, ee; int cyc;
    set_digits(2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00);
    gap[2] = 2;
    model(1024, 0, ex, ey, ee);
    run_op(16'd1024, 16'd0, ox, oy, oe, cyc);
    checks++;
    if (ox !== ex || oy !== ey || cyc != N + 3)
      $display("FAIL d_gaps got %0d,%0d lat=%0d want %0d,%0d lat=%0d",
               $signed(ox), $signed(oy), cyc,
               $signed(ex), $signed(ey), N + 3);
    else passed++;
    consume();
  endtask

  task automatic test_ena_pause();
    logic [15:0] ox, oy, ex, ey; logic oe, ee; int cyc;
    set_digits(2'b01, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b01);
    pause_at = 2; pause_len = 3;
    model(-2000, 9000, ex, ey, ee);
    run_op(-16'sd2000, 16'd9000, ox, oy, oe, cyc);
    checks++;
    if (ox !== ex || oy !== ey || cyc != N + 4)
      $display("FAIL ena_pause got %0d,%0d lat=%0d want %0d,%0d lat=%0d",
               $signed(ox), $signed(oy), cyc,
               $signed(ex), $signed(ey), N + 4);
    else passed++;
    consume();
  endtask

  task automatic test_reset_mid();
    logic [15:0] ox, oy, ex, ey; logic oe, ee; int cyc;
    set_digits(2'b01, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00);
    in_valid = 1; x_in = 16'd1024; y_in = 16'd0;
    @(negedge clk);
    in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      d_valid = 1; d_x = dq_x[i]; d_y = dq_y[i];
      @(negedge clk);
    end
    d_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if ({in_ready, d_ready, out_valid, d_err} !== 4'b1000 ||
        x_out !== 16'd0 || y_out !== 16'd0)
      $display("FAIL reset_mid got %b %0d,%0d want 1000 0,0",
               {in_ready, d_ready, out_valid, d_err}, x_out, y_out);
    else passed++;
    set_digits(2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00);
    model(1024, 0, ex, ey, ee);
    run_op(16'd1024, 16'd0, ox, oy, oe, cyc);
    checks++;
    if (ox !== ex || oy !== ey || oe !== ee || cyc != N + 1)
      $display("FAIL after_reset got %0d,%0d lat=%0d want %0d,%0d lat=%0d",
               $signed(ox), $signed(oy), cyc,
               $signed(ex), $signed(ey), N + 1);
    else passed++;
    consume();
  endtask

  initial begin
    rst = 1; ena = 1; in_valid = 0; x_in = 0; y_in = 0;
    d_valid = 0; d_x = 0; d_y = 0; out_ready = 0; junk_rdy = 0;
    set_digits(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_hold_output();
    test_in_pulse_run();
    test_d_gaps();
    test_ena_pause();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
